// File: rtl/ni_tx_vc_sched.sv
// Wormhole scheduler: picks one TX virtual channel per packet and streams it to the NI packet path.
// Optional build macro NI_TX_RR_ARB_EN selects round-robin arbitration instead of fixed priority.
module ni_tx_vc_sched #(
    parameter int N_VIRT_CHN      = 3,
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int PKT_WIDTH       = 8,
    parameter int VC_ID_WIDTH     = $clog2(N_VIRT_CHN)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_VIRT_CHN-1:0]                 vc_valid,
    input  logic [N_VIRT_CHN*FLIT_DATA_WIDTH-1:0] vc_flit,
    input  logic [N_VIRT_CHN*PKT_WIDTH-1:0]       vc_pkt_sz,
    output logic [N_VIRT_CHN-1:0]                 vc_ready,
    output logic                                  out_valid,
    output logic                                  out_req_new,
    output logic                                  out_req_last,
    output logic [VC_ID_WIDTH-1:0]                out_vc_id,
    output logic [FLIT_DATA_WIDTH-1:0]            out_flit,
    output logic [PKT_WIDTH-1:0]                  out_pkt_sz,
    input  logic                                  out_ready,
    output logic                                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [PKT_WIDTH-1:0] L_ONE  = {{(PKT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PKT_WIDTH-1:0] L_ZERO = {PKT_WIDTH{1'b0}};

    state_t                 r_state;
    logic [VC_ID_WIDTH-1:0] r_lock_vc;
    logic [PKT_WIDTH-1:0]   r_flit_cnt;

    logic [VC_ID_WIDTH-1:0] w_grant;
    logic [VC_ID_WIDTH-1:0] w_sel;
    logic [PKT_WIDTH-1:0]   w_sz_raw;
    logic [PKT_WIDTH-1:0]   w_sz;
    logic                   w_idle;
    logic                   w_valid;
    logic                   w_last;
    logic                   w_hs;

`ifdef NI_TX_RR_ARB_EN
    logic [VC_ID_WIDTH-1:0] r_rr_ptr;
    logic                   w_found;
    int                     w_idx;

    // Round-robin grant: first valid VC at or after r_rr_ptr, wrapping past the top index.
    always_comb begin
        w_grant = {VC_ID_WIDTH{1'b0}};
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N_VIRT_CHN; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_VIRT_CHN) begin
                w_idx = w_idx - N_VIRT_CHN;
            end else begin
                w_idx = w_idx;
            end
            w_grant = (!w_found && vc_valid[w_idx]) ? VC_ID_WIDTH'(w_idx) : w_grant;
            w_found = w_found | vc_valid[w_idx];
        end
    end

    // Pointer moves just past the VC whose head was accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= {VC_ID_WIDTH{1'b0}};
        end else if (w_idle && w_hs) begin
            r_rr_ptr <= (w_grant == VC_ID_WIDTH'(N_VIRT_CHN-1)) ? {VC_ID_WIDTH{1'b0}}
                                                                : w_grant + 1'b1;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`else
    // Fixed priority grant: the highest valid index wins.
    always_comb begin
        w_grant = {VC_ID_WIDTH{1'b0}};
        for (int i = 0; i < N_VIRT_CHN; i++) begin
            w_grant = vc_valid[i] ? VC_ID_WIDTH'(i) : w_grant;
        end
    end
`endif

    assign w_idle   = (r_state == ST_IDLE);
    assign w_sel    = w_idle ? w_grant : r_lock_vc;
    assign w_sz_raw = vc_pkt_sz[w_grant*PKT_WIDTH +: PKT_WIDTH];
    assign w_sz     = (w_sz_raw == L_ZERO) ? L_ONE : w_sz_raw;
    assign w_valid  = w_idle ? (|vc_valid) : vc_valid[r_lock_vc];
    assign w_last   = w_idle ? (w_sz == L_ONE) : (r_flit_cnt == L_ONE);
    assign w_hs     = w_valid & out_ready;

    // Zero-latency pass-through of the selected VC; everything forced low while in reset.
    always_comb begin
        vc_ready     = {N_VIRT_CHN{1'b0}};
        out_valid    = 1'b0;
        out_req_new  = 1'b0;
        out_req_last = 1'b0;
        out_vc_id    = {VC_ID_WIDTH{1'b0}};
        out_flit     = {FLIT_DATA_WIDTH{1'b0}};
        out_pkt_sz   = L_ZERO;
        busy         = 1'b0;
        if (rst_n) begin
            for (int i = 0; i < N_VIRT_CHN; i++) begin
                vc_ready[i] = out_ready & (w_sel == VC_ID_WIDTH'(i));
            end
            out_valid    = w_valid;
            out_req_new  = w_idle;
            out_req_last = w_last;
            out_vc_id    = w_sel;
            out_flit     = vc_flit[w_sel*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
            out_pkt_sz   = w_idle ? w_sz : L_ZERO;
            busy         = ~w_idle;
        end else begin
            busy = 1'b0;
        end
    end

    // Packet FSM: lock the granted VC on a multi-flit head, count down to its tail.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lock_vc  <= {VC_ID_WIDTH{1'b0}};
            r_flit_cnt <= L_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs && !w_last) begin
                        r_state    <= ST_BURST;
                        r_lock_vc  <= w_grant;
                        r_flit_cnt <= w_sz - L_ONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (w_hs) begin
                        r_flit_cnt <= r_flit_cnt - L_ONE;
                        r_state    <= w_last ? ST_IDLE : ST_BURST;
                    end else begin
                        r_state <= ST_BURST;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ni_tx_vc_sched.sv
// Randomised scoreboard bench for ni_tx_vc_sched: per-VC packet queues feed the DUT, a packet-level
// reference model predicts every presented flit, and a monitor compares on the falling edge.
module tb_ni_tx_vc_sched;

    localparam int NV = 3;
    localparam int FW = 32;
    localparam int PW = 8;
    localparam int VW = 2;

    logic               clk;
    logic               rst_n;
    logic [NV-1:0]      vc_valid;
    logic [NV*FW-1:0]   vc_flit;
    logic [NV*PW-1:0]   vc_pkt_sz;
    logic [NV-1:0]      vc_ready;
    logic               out_valid;
    logic               out_req_new;
    logic               out_req_last;
    logic [VW-1:0]      out_vc_id;
    logic [FW-1:0]      out_flit;
    logic [PW-1:0]      out_pkt_sz;
    logic               out_ready;
    logic               busy;

    ni_tx_vc_sched #(
        .N_VIRT_CHN(NV), .FLIT_DATA_WIDTH(FW), .PKT_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vc_valid(vc_valid), .vc_flit(vc_flit),
        .vc_pkt_sz(vc_pkt_sz), .vc_ready(vc_ready), .out_valid(out_valid),
        .out_req_new(out_req_new), .out_req_last(out_req_last), .out_vc_id(out_vc_id),
        .out_flit(out_flit), .out_pkt_sz(out_pkt_sz), .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          vc;
        bit          new_f;
        bit          last_f;
        logic [31:0] flit;
        int          sz;
        logic [2:0]  rdy;
    } exp_t;

    exp_t sb[$];
    bit   exp_busy;
    int   checks;
    int   errors;

    // Upstream VC buffers: queue of raw packet sizes, position within head packet, packet sequence.
    int q_sz [NV][$];
    int pos  [NV];
    int seq  [NV];

    // Reference model state: locked VC (-1 when none), flits still owed by it, round-robin pointer.
    int m_lock;
    int m_left;
    int m_rr;

    function automatic int eff_len(int raw);
        return (raw == 0) ? 1 : raw;
    endfunction

    function automatic logic [31:0] flit_of(int v, int s, int p);
        logic [31:0] f;
        f = {8'(v), 8'(s), 16'(p)};
        return f;
    endfunction

    // Falling-edge monitor: reset outputs, busy, and every presented flit against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (vc_ready !== 3'b000 || out_valid !== 1'b0 || out_req_new !== 1'b0 ||
                out_req_last !== 1'b0 || out_vc_id !== 2'd0 || out_flit !== 32'd0 ||
                out_pkt_sz !== 8'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got rdy=%b v=%b new=%b last=%b vc=%0d flit=%h sz=%0d busy=%b, need all 0",
                         vc_ready, out_valid, out_req_new, out_req_last, out_vc_id, out_flit, out_pkt_sz, busy);
            end
        end else begin
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy: got %b, need %b", busy, exp_busy);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 vc=%0d, need out_valid=0", out_vc_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (int'(out_vc_id) != e.vc || out_req_new !== e.new_f || out_req_last !== e.last_f ||
                        out_flit !== e.flit || vc_ready !== e.rdy ||
                        (e.new_f && int'(out_pkt_sz) != e.sz)) begin
                        errors++;
                        $display("FAIL flit: got vc=%0d new=%b last=%b flit=%h sz=%0d rdy=%b, need vc=%0d new=%b last=%b flit=%h sz=%0d rdy=%b",
                                 out_vc_id, out_req_new, out_req_last, out_flit, out_pkt_sz, vc_ready,
                                 e.vc, e.new_f, e.last_f, e.flit, e.sz, e.rdy);
                    end
                end
            end else if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_valid: got out_valid=0, need flit vc=%0d flit=%h", e.vc, e.flit);
            end
        end
    end

    // Stimulus + reference model: one iteration per clock, inputs driven 1 time unit after the edge.
    initial begin
        bit prev_rst;
        bit prev_hs;
        int prev_vc;
        int rst_left;
        bit rst_pend;
        int grant;
        bit found;
        bit ev;
        int ev_vc;
        bit [NV-1:0] vmask;

        checks = 0; errors = 0;
        exp_busy = 1'b0;
        m_lock = -1; m_left = 0; m_rr = 0;
        for (int v = 0; v < NV; v++) begin
            pos[v] = 0; seq[v] = 0;
        end
        rst_n     = 1'b0;
        out_ready = 1'b1;
        vc_valid  = 3'b111;
        vc_flit   = {$urandom, $urandom, $urandom};
        vc_pkt_sz = 24'h030201;
        prev_rst = 1'b1; prev_hs = 1'b0; prev_vc = 0;
        rst_left = 1; rst_pend = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            // Commit what the DUT sampled at this edge.
            if (prev_rst) begin
                m_lock = -1; m_left = 0; m_rr = 0;
                for (int v = 0; v < NV; v++) begin
                    if (pos[v] > 0) begin
                        void'(q_sz[v].pop_front());
                        pos[v] = 0;
                        seq[v]++;
                    end
                end
            end else if (prev_hs) begin
                int len;
                len = eff_len(q_sz[prev_vc][0]);
                pos[prev_vc]++;
                if (m_lock < 0) begin
                    m_rr = (prev_vc + 1) % NV;
                    if (len > 1) begin
                        m_lock = prev_vc;
                        m_left = len - 1;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) m_lock = -1;
                end
                if (pos[prev_vc] == len) begin
                    void'(q_sz[prev_vc].pop_front());
                    pos[prev_vc] = 0;
                    seq[prev_vc]++;
                end
            end

            // Top up upstream buffers; mostly short packets, occasionally 0/1 and the maximum.
            for (int v = 0; v < NV; v++) begin
                if (q_sz[v].size() < 3 && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 59) == 0) q_sz[v].push_back(255);
                    else                            q_sz[v].push_back(int'($urandom_range(0, 6)));
                end
            end

            // Reset: initial pulse, plus a mid-packet reset requested periodically.
            if (rst_left > 0) begin
                rst_n = 1'b0;
                rst_left--;
            end else begin
                rst_n = 1'b1;
                if (cyc % 900 == 450) rst_pend = 1'b1;
                if (rst_pend && m_lock >= 0 && pos[m_lock] >= 2) begin
                    rst_n = 1'b0;
                    rst_left = 1;
                    rst_pend = 1'b0;
                end
            end

            // Drive VC heads with random gaps; non-head flits carry junk in the size field.
            for (int v = 0; v < NV; v++) begin
                vmask[v] = (q_sz[v].size() > 0) && ($urandom_range(0, 3) != 0);
                if (q_sz[v].size() > 0) begin
                    vc_flit[v*FW +: FW] = flit_of(v, seq[v], pos[v]);
                    vc_pkt_sz[v*PW +: PW] = (pos[v] == 0) ? 8'(q_sz[v][0]) : 8'($urandom);
                end else begin
                    vc_flit[v*FW +: FW] = $urandom;
                    vc_pkt_sz[v*PW +: PW] = 8'($urandom);
                end
            end
            vc_valid = vmask;

            case ((cyc / 250) % 3)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = ($urandom_range(0, 7) == 0) ? 1'b1 : ((cyc % 16) < 10);
            endcase

            // Predict the flit presented this cycle.
            ev = 1'b0; ev_vc = 0;
            if (m_lock < 0) begin
                found = 1'b0; grant = 0;
`ifdef NI_TX_RR_ARB_EN
                for (int k = 0; k < NV; k++) begin
                    if (!found && vmask[(m_rr + k) % NV]) begin
                        grant = (m_rr + k) % NV;
                        found = 1'b1;
                    end
                end
`else
                for (int v = NV - 1; v >= 0; v--) begin
                    if (!found && vmask[v]) begin
                        grant = v;
                        found = 1'b1;
                    end
                end
`endif
                if (found) begin
                    exp_t e;
                    e.vc = grant; e.new_f = 1'b1;
                    e.sz = eff_len(q_sz[grant][0]);
                    e.last_f = (e.sz == 1);
                    e.flit = flit_of(grant, seq[grant], pos[grant]);
                    e.rdy = out_ready ? 3'(1 << grant) : 3'b000;
                    ev = 1'b1; ev_vc = grant;
                    if (rst_n) sb.push_back(e);
                end
            end else if (vmask[m_lock]) begin
                exp_t e;
                e.vc = m_lock; e.new_f = 1'b0; e.sz = 0;
                e.last_f = (m_left == 1);
                e.flit = flit_of(m_lock, seq[m_lock], pos[m_lock]);
                e.rdy = out_ready ? 3'(1 << m_lock) : 3'b000;
                ev = 1'b1; ev_vc = m_lock;
                if (rst_n) sb.push_back(e);
            end
            exp_busy = (m_lock >= 0);

            prev_rst = !rst_n;
            prev_hs  = rst_n && ev && out_ready;
            prev_vc  = ev_vc;
        end

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
